// File: rtl/playfield_engine.sv
// Settled-cell store for the falling-block game: merges a 4x4 piece, clears full rows
// bottom-up with shift-down, tracks score/top-out, and answers combinational collision queries.
module playfield_engine #(
    parameter int COLS        = 10,
    parameter int ROWS        = 24,
    parameter int HIDDEN_ROWS = 2,
    parameter int POS_W       = 6,
    parameter int SCORE_W     = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    clear_board,
    input  logic                    merge_req,
    input  logic [15:0]             piece,
    input  logic signed [POS_W-1:0] pos_x,
    input  logic signed [POS_W-1:0] pos_y,
    input  logic [15:0]             q_piece,
    input  logic signed [POS_W-1:0] q_x,
    input  logic signed [POS_W-1:0] q_y,
    output logic                    collide,
    output logic                    busy,
    output logic                    merge_done,
    output logic [2:0]              lines_cleared,
    output logic [SCORE_W-1:0]      score,
    output logic                    topout,
    output logic [ROWS*COLS-1:0]    board
);

    localparam int NCELL = ROWS * COLS;
    localparam int IDX_W = $clog2(NCELL);
    localparam int RP_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, MERGE, SCAN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [NCELL-1:0]          board_q, board_d;
    logic [15:0]               piece_q, piece_d;
    logic signed [POS_W-1:0]   px_q, px_d, py_q, py_d;
    logic [RP_W-1:0]           rp_q, rp_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                lines_q, lines_d;
    logic [SCORE_W-1:0]        score_q, score_d;
    logic                      topout_q, topout_d;

    logic [NCELL-1:0]          merged_board;
    logic [NCELL-1:0]          shifted_board;
    logic                      row_full;
    logic                      hit;
    logic [SCORE_W+2:0]        score_sum;

    // Piece cells landing outside the board are simply dropped.
    always_comb begin : merge_comb
        int mrow, mcol;
        merged_board = board_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                mrow = int'(py_q) + r;
                mcol = int'(px_q) + c;
                if (piece_q[4*r+c] && mrow >= 0 && mrow < ROWS && mcol >= 0 && mcol < COLS)
                    merged_board[IDX_W'(mrow*COLS + mcol)] = 1'b1;
            end
        end
    end

    // Rows 1..rp take the row above; row 0 empties. Rows below rp are untouched.
    always_comb begin
        row_full      = 1'b0;
        shifted_board = board_q;
        for (int r = 0; r < ROWS; r++) begin
            if (RP_W'(r) == rp_q)
                row_full = &board_q[r*COLS +: COLS];
            if (RP_W'(r) <= rp_q) begin
                if (r == 0)
                    shifted_board[0 +: COLS] = '0;
                else
                    shifted_board[r*COLS +: COLS] = board_q[(r-1)*COLS +: COLS];
            end
        end
    end

    always_comb begin : query_comb
        int qrow, qcol;
        hit = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                qrow = int'(q_y) + r;
                qcol = int'(q_x) + c;
                if (q_piece[4*r+c] && qrow >= 0) begin
                    if (qcol < 0 || qcol >= COLS || qrow >= ROWS)
                        hit = 1'b1;
                    else if (board_q[IDX_W'(qrow*COLS + qcol)])
                        hit = 1'b1;
                end
            end
        end
    end

    assign score_sum = {3'b000, score_q} + {{SCORE_W{1'b0}}, cnt_q};

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        piece_d  = piece_q;
        px_d     = px_q;
        py_d     = py_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        lines_d  = lines_q;
        score_d  = score_q;
        topout_d = topout_q;
        if (clear_board) begin
            state_d  = IDLE;
            board_d  = '0;
            cnt_d    = '0;
            lines_d  = '0;
            score_d  = '0;
            topout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (merge_req) begin
                    piece_d = piece;
                    px_d    = pos_x;
                    py_d    = pos_y;
                    state_d = MERGE;
                end
                MERGE: begin
                    board_d = merged_board;
                    rp_d    = RP_W'(ROWS - 1);
                    cnt_d   = '0;
                    state_d = SCAN;
                end
                SCAN: begin
                    // A cleared row leaves rp in place so the row shifted into it is rechecked.
                    if (row_full) begin
                        board_d = shifted_board;
                        if (cnt_q != 3'd4)
                            cnt_d = cnt_q + 3'd1;
                    end else if (rp_q == '0) begin
                        state_d  = DONE;
                        lines_d  = cnt_q;
                        score_d  = (|score_sum[SCORE_W+2:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
                        topout_d = topout_q | (|board_q[HIDDEN_ROWS*COLS-1:0]);
                    end else begin
                        rp_d = rp_q - 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            board_q  <= '0;
            piece_q  <= '0;
            px_q     <= '0;
            py_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            lines_q  <= '0;
            score_q  <= '0;
            topout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            piece_q  <= piece_d;
            px_q     <= px_d;
            py_q     <= py_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            lines_q  <= lines_d;
            score_q  <= score_d;
            topout_q <= topout_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign merge_done    = (state_q == DONE);
    assign collide       = busy | hit;
    assign lines_cleared = lines_q;
    assign score         = score_q;
    assign topout        = topout_q;
    assign board         = board_q;

endmodule

// File: tb/tb_playfield_engine.sv
// Bench for playfield_engine: collision vector table, reference-model scoreboard for merges,
// and hand-written sequences for ignored requests, mid-scan clear, saturation and top-out.
module tb_playfield_engine;

    localparam int COLS = 10;
    localparam int ROWS = 24;
    localparam int HID  = 2;
    localparam int NC   = ROWS * COLS;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              clear_board = 1'b0;
    logic              merge_req = 1'b0;
    logic [15:0]       piece = '0;
    logic signed [5:0] pos_x = '0, pos_y = '0;
    logic [15:0]       q_piece = '0;
    logic signed [5:0] q_x = '0, q_y = '0;

    logic          collide, busy, merge_done, topout;
    logic [2:0]    lines_cleared;
    logic [15:0]   score;
    logic [NC-1:0] board;
    logic          collide_3, busy_3, merge_done_3, topout_3;
    logic [2:0]    lines_cleared_3;
    logic [2:0]    score_3;
    logic [NC-1:0] board_3;

    playfield_engine dut (
        .Clk(Clk), .Reset(Reset), .clear_board(clear_board), .merge_req(merge_req),
        .piece(piece), .pos_x(pos_x), .pos_y(pos_y), .q_piece(q_piece), .q_x(q_x), .q_y(q_y),
        .collide(collide), .busy(busy), .merge_done(merge_done), .lines_cleared(lines_cleared),
        .score(score), .topout(topout), .board(board));

    playfield_engine #(.SCORE_W(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .clear_board(clear_board), .merge_req(merge_req),
        .piece(piece), .pos_x(pos_x), .pos_y(pos_y), .q_piece(q_piece), .q_x(q_x), .q_y(q_y),
        .collide(collide_3), .busy(busy_3), .merge_done(merge_done_3), .lines_cleared(lines_cleared_3),
        .score(score_3), .topout(topout_3), .board(board_3));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    typedef struct {
        logic [NC-1:0] board;
        logic [2:0]    lines;
        logic [15:0]   score;
        logic [2:0]    score3;
        logic          topout;
        int            acc;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   done_cnt = 0;
    int   last_lat = 0;

    logic [NC-1:0] mdl_board = '0;
    int            mdl_score = 0, mdl_score3 = 0;
    logic          mdl_topout = 1'b0;

    always @(negedge Clk) begin
        if (merge_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_merge_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                last_lat = cyc - e.acc;
                chk("latency", last_lat, e.lat);
                chk("done_board", board, e.board);
                chk("done_board_s3", board_3, e.board);
                chk("lines_cleared", lines_cleared, e.lines);
                chk("score", score, e.score);
                chk("score_s3", score_3, e.score3);
                chk("topout", topout, e.topout);
                chk("merge_done_s3", merge_done_3, 1);
            end
        end
    end

    // Reference: keep non-full rows in order, packed against the bottom.
    task automatic model_merge(input logic [15:0] p, input int x, input int y);
        logic [NC-1:0] nb, nb2;
        int k, dst, rr, cc;
        exp_t ex;
        nb = mdl_board;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                rr = y + r; cc = x + c;
                if (p[4*r+c] && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) nb[rr*COLS+cc] = 1'b1;
            end
        nb2 = '0; k = 0; dst = ROWS - 1;
        for (int src = ROWS - 1; src >= 0; src--) begin
            if (nb[src*COLS +: COLS] == {COLS{1'b1}}) k++;
            else begin nb2[dst*COLS +: COLS] = nb[src*COLS +: COLS]; dst--; end
        end
        mdl_board  = nb2;
        mdl_score  = (mdl_score + k > 65535) ? 65535 : mdl_score + k;
        mdl_score3 = (mdl_score3 + k > 7) ? 7 : mdl_score3 + k;
        mdl_topout = mdl_topout | (|nb2[HID*COLS-1:0]);
        ex.board = nb2; ex.lines = 3'(k); ex.score = 16'(mdl_score); ex.score3 = 3'(mdl_score3);
        ex.topout = mdl_topout; ex.acc = cyc + 1; ex.lat = ROWS + 1 + k;
        sb_q.push_back(ex);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic launch(input logic [15:0] p, input int x, input int y);
        merge_req = 1'b1; piece = p; pos_x = 6'(x); pos_y = 6'(y);
        model_merge(p, x, y);
        @(negedge Clk);
        merge_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge Clk);
        chk("idle_timeout", busy, 0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    task automatic merge(input logic [15:0] p, input int x, input int y);
        launch(p, x, y);
        wait_idle();
    endtask

    task automatic do_clear();
        clear_board = 1'b1;
        sb_q.delete();
        mdl_board = '0; mdl_score = 0; mdl_score3 = 0; mdl_topout = 1'b0;
        @(negedge Clk);
        clear_board = 1'b0;
    endtask

    typedef struct {
        logic [15:0]       p;
        logic signed [5:0] x;
        logic signed [5:0] y;
        logic              exp;
    } qv_t;

    qv_t qv[14];
    logic [NC-1:0] hb;
    int d0;

    initial begin
        qv[0]  = '{16'h0001, 6'h3F, 6'h00, 1'b1};
        qv[1]  = '{16'h0001, 6'h09, 6'h00, 1'b0};
        qv[2]  = '{16'h0001, 6'h0A, 6'h00, 1'b1};
        qv[3]  = '{16'h0001, 6'h00, 6'h17, 1'b0};
        qv[4]  = '{16'h0001, 6'h00, 6'h18, 1'b1};
        qv[5]  = '{16'h0001, 6'h00, 6'h3D, 1'b0};
        qv[6]  = '{16'h0001, 6'h03, 6'h16, 1'b1};
        qv[7]  = '{16'h0001, 6'h07, 6'h16, 1'b0};
        qv[8]  = '{16'h000F, 6'h06, 6'h00, 1'b0};
        qv[9]  = '{16'h000F, 6'h07, 6'h00, 1'b1};
        qv[10] = '{16'h1000, 6'h00, 6'h14, 1'b0};
        qv[11] = '{16'h1000, 6'h00, 6'h15, 1'b1};
        qv[12] = '{16'h8000, 6'h00, 6'h13, 1'b1};
        qv[13] = '{16'h0000, 6'h3B, 6'h1E, 1'b0};

        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        q_piece = 16'h000F; q_x = 6'h00; q_y = 6'h00;
        repeat (5) @(negedge Clk);
        chk("rst_board", board, 0);
        chk("rst_score", score, 0);
        chk("rst_topout", topout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", merge_done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_collide", collide, 0);

        // Single horizontal I onto an empty board.
        launch(16'h000F, 3, 22);
        chk("busy_after_accept", busy, 1);
        @(negedge Clk);
        hb = '0; hb[223 +: 4] = 4'hF;
        chk("board_after_merge_edge", board, hb);
        wait_idle();
        chk("i_latency", last_lat, 25);
        chk("i_board", board, hb);
        chk("i_lines", lines_cleared, 0);

        foreach (qv[i]) begin
            q_piece = qv[i].p; q_x = qv[i].x; q_y = qv[i].y;
            #1;
            chk($sformatf("collide_vec%0d", i), collide, qv[i].exp);
        end

        // Two separated full rows with one row of debris between them.
        do_clear();
        merge(16'h000F, 1, 23); merge(16'h000F, 5, 23); merge(16'h0001, 9, 23);
        merge(16'h000F, 1, 21); merge(16'h000F, 5, 21); merge(16'h0001, 9, 21);
        merge(16'h0001, 4, 22);
        merge(16'h0101, 0, 21);
        hb = '0; hb[234] = 1'b1;
        chk("dbl_board", board, hb);
        chk("dbl_lines", lines_cleared, 2);
        chk("dbl_score", score, 2);
        chk("dbl_latency", last_lat, 27);

        // A second request three cycles into a merge is dropped; collide forced while busy.
        q_piece = 16'h0001; q_x = 6'h09; q_y = 6'h00;
        d0 = done_cnt;
        launch(16'h000F, 0, 10);
        @(negedge Clk);
        chk("collide_busy", collide, 1);
        @(negedge Clk);
        merge_req = 1'b1; piece = 16'hFFFF; pos_x = 6'h00; pos_y = 6'h00;
        @(negedge Clk);
        merge_req = 1'b0;
        wait_idle();
        repeat (30) @(negedge Clk);
        chk("ignored_req_done_count", done_cnt - d0, 1);

        // Clear while scanning abandons the merge.
        launch(16'h000F, 0, 5);
        repeat (10) @(negedge Clk);
        d0 = done_cnt;
        do_clear();
        chk("clr_board", board, 0);
        chk("clr_busy", busy, 0);
        chk("clr_score", score, 0);
        repeat (30) @(negedge Clk);
        chk("clr_no_done", done_cnt - d0, 0);

        // Eight single-line merges.
        for (int n = 0; n < 8; n++) begin
            merge(16'h000F, 1, 23); merge(16'h000F, 5, 23); merge(16'h0001, 9, 23);
            merge(16'h0001, 0, 23);
        end
        chk("sat_score3", score_3, 7);
        chk("sat_score16", score, 8);

        // Top-out is sticky until cleared.
        do_clear();
        merge(16'h0001, 0, 1);
        chk("topout_set", topout, 1);
        merge(16'h0001, 5, 23);
        chk("topout_sticky", topout, 1);
        do_clear();
        chk("topout_cleared", topout, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
